// File: rtl/mole_hit_detector.sv
// Mole hit detector: maps a click at screen (x,y) back to a raised mole.
// Tracks per-hole mole heights and scans the 12 holes one per cycle.
module mole_hit_detector #(
  parameter int HOLE_W         = 42,
  parameter int MAX_HEIGHT     = 40,
  parameter int MIN_HIT_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        anim_tick,
  input  logic [9:0]  mouse_x_pos,
  input  logic [8:0]  mouse_y_pos,
  input  logic        mouse_click,
  input  logic [11:0] mole_up,
  input  logic        is_start,
  input  logic        is_pause,
  output logic        hit_valid,
  output logic [3:0]  hit_index,
  output logic        miss_valid,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [9:0]  x_lat;
  logic [8:0]  y_lat;
  logic        res_hit;
  logic [5:0]  h [12];

  logic [10:0] x0;
  logic [10:0] base;
  logic [5:0]  cur_h;
  logic [10:0] xl;
  logic [10:0] yl;
  logic [10:0] top;
  logic        match;

  // Mole rise/fall animation, identical to the renderer's.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 12; i++) h[i] <= '0;
    end else if (anim_tick && !is_pause) begin
      for (int i = 0; i < 12; i++) begin
        if (mole_up[i] && h[i] < 6'(MAX_HEIGHT))
          h[i] <= h[i] + 6'd1;
        else if (!mole_up[i] && h[i] != 6'd0)
          h[i] <= h[i] - 6'd1;
      end
    end
  end

  always_comb begin
    x0    = '0;
    base  = '0;
    cur_h = '0;
    case (idx)
      4'd0:  begin x0 = 11'd111; base = 11'd307; cur_h = h[0];  end
      4'd1:  begin x0 = 11'd230; base = 11'd307; cur_h = h[1];  end
      4'd2:  begin x0 = 11'd349; base = 11'd307; cur_h = h[2];  end
      4'd3:  begin x0 = 11'd468; base = 11'd307; cur_h = h[3];  end
      4'd4:  begin x0 = 11'd98;  base = 11'd352; cur_h = h[4];  end
      4'd5:  begin x0 = 11'd226; base = 11'd352; cur_h = h[5];  end
      4'd6:  begin x0 = 11'd354; base = 11'd352; cur_h = h[6];  end
      4'd7:  begin x0 = 11'd483; base = 11'd352; cur_h = h[7];  end
      4'd8:  begin x0 = 11'd80;  base = 11'd406; cur_h = h[8];  end
      4'd9:  begin x0 = 11'd221; base = 11'd406; cur_h = h[9];  end
      4'd10: begin x0 = 11'd360; base = 11'd406; cur_h = h[10]; end
      4'd11: begin x0 = 11'd501; base = 11'd406; cur_h = h[11]; end
      default: begin x0 = '0; base = '0; cur_h = '0; end
    endcase
  end

  // Base is always >= 307 and height <= 63, so top never underflows.
  assign xl    = {1'b0, x_lat};
  assign yl    = {2'b0, y_lat};
  assign top   = base - {5'b0, cur_h};
  assign match = (xl >= x0) && (xl < x0 + 11'(HOLE_W))
              && (yl >= top) && (yl < base)
              && (cur_h >= 6'(MIN_HIT_HEIGHT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      x_lat      <= '0;
      y_lat      <= '0;
      res_hit    <= 1'b0;
      hit_valid  <= 1'b0;
      hit_index  <= '0;
      miss_valid <= 1'b0;
    end else begin
      hit_valid  <= 1'b0;
      miss_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mouse_click && is_start && !is_pause) begin
            x_lat <= mouse_x_pos;
            y_lat <= mouse_y_pos;
            idx   <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!is_start || is_pause) begin
            state <= S_IDLE;
          end else if (match) begin
            res_hit <= 1'b1;
            state   <= S_REPORT;
          end else if (idx == 4'd11) begin
            res_hit <= 1'b0;
            state   <= S_REPORT;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_REPORT: begin
          hit_valid  <= res_hit;
          miss_valid <= !res_hit;
          if (res_hit) hit_index <= idx;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mole_hit_detector.sv
// Self-checking bench for mole_hit_detector.
// Expected reports are queued at click time and matched against observed pulses.
module tb_mole_hit_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        anim_tick = 1'b0;
  logic [9:0]  mouse_x_pos = '0;
  logic [8:0]  mouse_y_pos = '0;
  logic        mouse_click = 1'b0;
  logic [11:0] mole_up = '0;
  logic        is_start = 1'b0;
  logic        is_pause = 1'b0;
  logic        hit_valid;
  logic [3:0]  hit_index;
  logic        miss_valid;
  logic        busy;

  typedef struct {
    bit       hit;
    bit [3:0] idx;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  passed = 0;
  int  cyc = 0;

  mole_hit_detector dut (
    .clk(clk), .reset(reset), .anim_tick(anim_tick),
    .mouse_x_pos(mouse_x_pos), .mouse_y_pos(mouse_y_pos),
    .mouse_click(mouse_click), .mole_up(mole_up),
    .is_start(is_start), .is_pause(is_pause),
    .hit_valid(hit_valid), .hit_index(hit_index),
    .miss_valid(miss_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every report pulse just after the edge that launched it.
  always @(posedge clk) begin
    ev_t o;
    #1;
    if (hit_valid || miss_valid) begin
      o.hit = hit_valid;
      o.idx = hit_index;
      o.cyc = cyc;
      obs_q.push_back(o);
      checks++;
      if (hit_valid && miss_valid)
        $display("FAIL both_pulses hit=%b miss=%b want not both", hit_valid, miss_valid);
      else
        passed++;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    mouse_click = 1'b0;
    anim_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) anim_tick = 1'b1;
      @(negedge clk) anim_tick = 1'b0;
    end
  endtask

  task automatic click_expect(input string name, input int x, input int y,
                              input bit eh, input int ek);
    int  c, bc, lat;
    ev_t e, o;
    @(negedge clk);
    mouse_x_pos = 10'(x);
    mouse_y_pos = 9'(y);
    mouse_click = 1'b1;
    @(negedge clk);
    mouse_click = 1'b0;
    c = cyc;
    lat = eh ? 2 + ek : 13;
    e.hit = eh;
    e.idx = eh ? 4'(ek) : 4'd0;
    e.cyc = c + lat;
    exp_q.push_back(e);
    bc = 0;
    for (int n = 0; n < 20 && obs_q.size() == 0; n++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    checks++;
    if (obs_q.size() == 0) begin
      $display("FAIL %s timeout: no report, want hit=%b", name, eh);
      void'(exp_q.pop_front());
      return;
    end
    passed++;
    o = obs_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    if (o.hit !== e.hit)
      $display("FAIL %s kind got hit=%b want hit=%b", name, o.hit, e.hit);
    else passed++;
    checks++;
    if (o.cyc !== e.cyc)
      $display("FAIL %s latency got %0d want %0d", name, o.cyc - c, e.cyc - c);
    else passed++;
    checks++;
    if (bc !== lat)
      $display("FAIL %s busy_cycles got %0d want %0d", name, bc, lat);
    else passed++;
    if (e.hit) begin
      checks++;
      if (o.idx !== e.idx)
        $display("FAIL %s index got %0d want %0d", name, o.idx, e.idx);
      else passed++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, hit_valid, miss_valid, hit_index} !== 7'b0)
      $display("FAIL reset_outputs got %b want 0000000",
               {busy, hit_valid, miss_valid, hit_index});
    else passed++;
    reset = 1'b0;
    is_start = 1'b1;
  endtask

  task automatic test_hit_basic();
    apply_reset();
    mole_up = 12'h020;
    ticks(45);
    click_expect("hit5", 240, 330, 1, 5);
  endtask

  task automatic test_miss_edges();
    click_expect("x_right_excl", 268, 330, 0, 0);
    click_expect("x_left_out", 225, 330, 0, 0);
    click_expect("y_base_excl", 240, 352, 0, 0);
    click_expect("y_top_incl", 240, 312, 1, 5);
    click_expect("y_above_top", 240, 311, 0, 0);
  endtask

  task automatic test_saturation_top();
    apply_reset();
    mole_up = 12'h001;
    ticks(45);
    click_expect("hit0_top", 120, 267, 1, 0);
    click_expect("miss0_above", 120, 266, 0, 0);
    checks++;
    if (hit_index !== 4'd0)
      $display("FAIL index_hold got %0d want 0", hit_index);
    else passed++;
  endtask

  task automatic test_min_height();
    apply_reset();
    mole_up = 12'h020;
    ticks(5);
    click_expect("h5_low", 240, 350, 0, 0);
    ticks(3);
    click_expect("h8_hit", 240, 350, 1, 5);
    mole_up = 12'h000;
    ticks(1);
    click_expect("h7_fall", 240, 350, 0, 0);
  endtask

  task automatic test_pause();
    apply_reset();
    mole_up = 12'h020;
    is_pause = 1'b1;
    ticks(45);
    @(negedge clk);
    mouse_x_pos = 10'd240;
    mouse_y_pos = 9'd330;
    mouse_click = 1'b1;
    @(negedge clk);
    mouse_click = 1'b0;
    checks++;
    if (busy !== 1'b0)
      $display("FAIL pause_busy got %b want 0", busy);
    else passed++;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0)
      $display("FAIL pause_pulse got %0d reports want 0", obs_q.size());
    else passed++;
    is_pause = 1'b0;
    click_expect("pause_froze_h", 240, 330, 0, 0);
  endtask

  task automatic test_back_to_back();
    int  c;
    ev_t e, o;
    apply_reset();
    mole_up = 12'h020;
    ticks(45);
    @(negedge clk);
    mouse_x_pos = 10'd240;
    mouse_y_pos = 9'd330;
    mouse_click = 1'b1;
    @(negedge clk);
    mouse_click = 1'b0;
    c = cyc;
    e.hit = 1'b1;
    e.idx = 4'd5;
    e.cyc = c + 7;
    exp_q.push_back(e);
    @(negedge clk);
    mouse_x_pos = 10'd120;
    mouse_y_pos = 9'd10;
    mouse_click = 1'b1;
    @(negedge clk);
    mouse_click = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      $display("FAIL b2b_count got %0d want 1", obs_q.size());
      return;
    end
    passed++;
    o = obs_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    if (o.hit !== e.hit || o.idx !== e.idx || o.cyc !== e.cyc)
      $display("FAIL b2b_report got hit=%b idx=%0d lat=%0d want hit=%b idx=%0d lat=%0d",
               o.hit, o.idx, o.cyc - c, e.hit, e.idx, e.cyc - c);
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    apply_reset();
    mole_up = 12'h021;
    ticks(45);
    @(negedge clk);
    mouse_x_pos = 10'd240;
    mouse_y_pos = 9'd330;
    mouse_click = 1'b1;
    @(negedge clk);
    mouse_click = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, hit_valid, miss_valid} !== 3'b000)
      $display("FAIL midscan_reset got %b want 000", {busy, hit_valid, miss_valid});
    else passed++;
    mole_up = 12'h000;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0)
      $display("FAIL midscan_pulse got %0d reports want 0", obs_q.size());
    else passed++;
    obs_q.delete();
    click_expect("post_reset_h5", 240, 330, 0, 0);
    click_expect("post_reset_h0", 120, 290, 0, 0);
  endtask

  initial begin
    test_reset();
    test_hit_basic();
    test_miss_edges();
    test_saturation_top();
    test_min_height();
    test_pause();
    test_back_to_back();
    test_reset_mid_scan();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
